delay_line: RTL and testbench

Parametrised, stallable multi-stage register pipeline carrying a WIDTH-bit payload with per-stage valid bits. It is the next generation of the single-cycle flip-flop stage. Depth, width and reset value are configurable, and it adds valid/ready flow control with bubble collapsing, a synchronous flush and an occupancy count. It sits between a producer and consumer in any datapath needing a fixed minimum latency of DEPTH cycles, for example to align a signal with a temporal property check.

---
 rtl/delay_line_pkg.sv | 14 +
 rtl/delay_line_if.sv | 27 ++
 rtl/delay_stage.sv | 30 +++
 rtl/delay_line.sv | 84 ++++++++
 tb/tb_delay_line.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared helpers for the delay_line pipeline
package delay_line_pkg;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal pipeline depths; used for the elaboration check in the top.
    function automatic bit depth_ok(input int depth);
        return depth >= 1;
    endfunction

endpackage

// File: rtl/delay_line_if.sv
// rtl/delay_line_if.sv - producer/consumer handshake bundle for delay_line
interface delay_line_if
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    logic [WIDTH-1:0]          I;
    logic                      I_valid;
    logic                      I_ready;
    logic [WIDTH-1:0]          O;
    logic                      O_valid;
    logic                      O_ready;
    logic                      FLUSH;
    logic [cnt_w(DEPTH)-1:0]   COUNT;
    logic                      EMPTY;

    modport master (
        output I, I_valid, O_ready, FLUSH,
        input  I_ready, O, O_valid, COUNT, EMPTY
    );

    modport slave (
        input  I, I_valid, O_ready, FLUSH,
        output I_ready, O, O_valid, COUNT, EMPTY
    );
endinterface

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one data+valid register of the delay pipeline
module delay_stage #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Flush beats advance; a non-advancing stage holds data and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= INIT;
            q_valid <= 1'b0;
        end else if (flush) begin
            q       <= INIT;
            q_valid <= 1'b0;
        end else if (adv) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/delay_line.sv
// rtl/delay_line.sv - stallable DEPTH-stage register pipeline with bubble collapsing
module delay_line
    import delay_line_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic        CLK,
    input  logic        ASYNCRESETN,
    delay_line_if.slave bus
);

    localparam int CW = cnt_w(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("delay_line: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   adv;
    logic [CW-1:0]    count;
    logic             in_xfer;
    logic             out_xfer;

    // Ready chain from the consumer back to stage 0: an empty stage always
    // advances, so bubbles collapse even while the output is stalled.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = bus.O_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = !valid[k] || adv[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d;
        logic             d_valid;

        if (k == 0) begin : g_head
            assign d       = bus.I;
            assign d_valid = bus.I_valid;
        end else begin : g_body
            assign d       = data[k-1];
            assign d_valid = valid[k-1];
        end

        delay_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk     (CLK),
            .rst_n   (ASYNCRESETN),
            .adv     (adv[k]),
            .flush   (bus.FLUSH),
            .d       (d),
            .d_valid (d_valid),
            .q       (data[k]),
            .q_valid (valid[k])
        );
    end

    assign bus.I_ready = adv[0] && !bus.FLUSH;
    assign bus.O       = data[DEPTH-1];
    assign bus.O_valid = valid[DEPTH-1];
    assign in_xfer     = bus.I_valid && bus.I_ready;
    assign out_xfer    = bus.O_valid && bus.O_ready;

    // Occupancy tracks accepted-minus-delivered items; flush empties it.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count <= '0;
        end else if (bus.FLUSH) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    assign bus.COUNT = count;
    assign bus.EMPTY = (count == '0);

endmodule

// File: tb/tb_delay_line.sv
// tb/tb_delay_line.sv - scoreboard bench for delay_line (DEPTH=3 and DEPTH=1)
module tb_delay_line;
    import delay_line_pkg::*;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] INIT  = 8'hA5;
    localparam logic [7:0] INIT1 = 8'h3C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    delay_line_if #(.WIDTH(WIDTH), .DEPTH(1))     bus1 ();

    delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .bus         (bus)
    );

    delay_line #(.WIDTH(WIDTH), .DEPTH(1), .INIT(INIT1)) dut1 (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .bus         (bus1)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: items in flight, in order, with the edge they entered.
    typedef struct {
        logic [7:0] val;
        int         cap;
    } item_t;

    item_t      mq[$];
    logic [7:0] q1[$];
    int         edge_cnt = 0;

    // Stage 0 refuses only when every stage is full and the consumer stalls.
    function automatic bit pred_iready();
        return !bus.FLUSH && !(mq.size() == DEPTH && !bus.O_ready);
    endfunction

    // The oldest item is visible once it has had DEPTH-1 further edges to travel.
    function automatic bit pred_ovalid();
        return mq.size() > 0 && (edge_cnt - mq[0].cap >= DEPTH - 1);
    endfunction

    task automatic model_step();
        bit in_ok, out_ok, in1, out1;
        in_ok  = bus.I_valid && pred_iready();
        out_ok = pred_ovalid() && bus.O_ready;
        in1    = bus1.I_valid && (q1.size() == 0 || bus1.O_ready);
        out1   = q1.size() > 0 && bus1.O_ready;
        edge_cnt++;
        if (out_ok) void'(mq.pop_front());
        if (bus.FLUSH) mq.delete();
        else if (in_ok) mq.push_back('{val: bus.I, cap: edge_cnt});
        if (out1) void'(q1.pop_front());
        if (in1) q1.push_back(bus1.I);
    endtask

    // Model update at each active edge; async reset empties the model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            q1.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: compare DUT outputs against the model away from the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count",   32'(bus.COUNT),   32'(mq.size()));
            check("empty",   32'(bus.EMPTY),   32'(mq.size() == 0));
            check("i_ready", 32'(bus.I_ready), 32'(pred_iready()));
            check("o_valid", 32'(bus.O_valid), 32'(pred_ovalid()));
            if (pred_ovalid()) check("o_data", 32'(bus.O), 32'(mq[0].val));
            check("d1_o_valid", 32'(bus1.O_valid), 32'(q1.size() > 0));
            if (q1.size() > 0) check("d1_o_data", 32'(bus1.O), 32'(q1[0]));
            check("d1_i_ready", 32'(bus1.I_ready), 32'(q1.size() == 0 || bus1.O_ready));
        end
    end

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.I_valid = iv;
        bus.I       = d;
        bus.O_ready = ordy;
        bus.FLUSH   = fl;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, ordy, 1'b0);
    endtask

    // Free-running random traffic for the DEPTH=1 instance.
    initial begin
        bus1.I       = '0;
        bus1.I_valid = 1'b0;
        bus1.O_ready = 1'b0;
        bus1.FLUSH   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus1.I_valid = 1'($urandom_range(0, 1));
            bus1.I       = 8'($urandom);
            bus1.O_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        bus.I       = '0;
        bus.I_valid = 1'b0;
        bus.O_ready = 1'b0;
        bus.FLUSH   = 1'b0;

        #12;
        check("rst_o",       32'(bus.O),       32'(INIT));
        check("rst_o_valid", 32'(bus.O_valid), 32'd0);
        check("rst_count",   32'(bus.COUNT),   32'd0);
        check("rst_empty",   32'(bus.EMPTY),   32'd1);
        check("rst_i_ready", 32'(bus.I_ready), 32'd1);
        check("rst_d1_o",    32'(bus1.O),      32'(INIT1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming at full throughput.
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        idle(1'b1, 5);

        // Stall and fill, offer a fourth item while full, then drain.
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        idle(1'b1, 5);

        // Bubble collapse under output stall.
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        idle(1'b0, 2);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 4);

        // Flush with a concurrent offer.
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        drive(1'b1, 8'h30, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_o", 32'(bus.O), 32'(INIT));
        idle(1'b1, 3);

        // Simultaneous in/out transfers at full.
        drive(1'b1, 8'h50, 1'b0, 1'b0);
        drive(1'b1, 8'h51, 1'b0, 1'b0);
        drive(1'b1, 8'h52, 1'b0, 1'b0);
        for (int i = 3; i < 7; i++) drive(1'b1, 8'h50 + 8'(i), 1'b1, 1'b0);
        idle(1'b1, 5);

        // Asynchronous reset between edges with two items in flight.
        drive(1'b1, 8'h60, 1'b0, 1'b0);
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_o_valid", 32'(bus.O_valid), 32'd0);
        check("arst_count",   32'(bus.COUNT),   32'd0);
        check("arst_empty",   32'(bus.EMPTY),   32'd1);
        check("arst_o",       32'(bus.O),       32'(INIT));
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b1, 2);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && mq.size() > 0; i++) idle(1'b1, 1);
        idle(1'b1, 1);
        check("drain", 32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
